aggr_cost_feeder: RTL and testbench
===================================

# aggr_cost_feeder

Stream source for `aggregate_cost`. It reads per-pixel initial cost vectors from a synchronous memory in raster order. Each vector is presented on `cost_init` with `row`/`col` and a one-cycle `en` strobe, at a fixed pixel pacing interval. A `hold` input provides back-pressure, and the block can run one frame or loop frames continuously. It sits between the cost-volume buffer and `aggregate_cost`, and replaces the bench-driven stimulus in system builds.

## Interface
- `DATA_WIDTH`, 864, width of one cost vector (e.g. 108 disparities x 8 bit)
- `DIM_WIDTH`, 10, width of `row`/`col`
- `IMG_ROWS`, 200, frame height
- `IMG_COLS`, 400, frame width
- `ADDR_WIDTH`, 17, memory address width; must hold IMG_ROWS*IMG_COLS-1
- `ISSUE_INTERVAL`, 13, cycles between consecutive `en` pulses when not held; legal range ≥3
- `clk`  in  1  clock
- `rst`  in  1  reset; asynchronous, active-low
- `start`  in  1  begin a frame; sampled only when idle
- `loop`  in  1  1: start the next frame automatically after the last pixel
- `hold`  in  1  back-pressure; freezes pacing and `en`
- `mem_rd`  out  1  memory read strobe
- `mem_addr`  out  ADDR_WIDTH  linear pixel index row*IMG_COLS+col
- `mem_rdata`  in  DATA_WIDTH  read data, valid exactly one cycle after `mem_rd`
- `cost_init`  out  DATA_WIDTH  cost vector to `aggregate_cost`
- `row`, `col`  out  DIM_WIDTH  coordinates of `cost_init`
- `en`  out  1  one-cycle qualifier for `cost_init`/`row`/`col`
- `busy`  out  1  high from accepted `start` until the frame ends
- `frame_done`  out  1  one-cycle pulse coincident with the last pixel's `en`
- `frame_cnt`  out  5  completed frames; wraps 31→0

## Operation
- FSM states:
  - IDLE: `busy`=0. `start`=1 → READ.
  - READ: `mem_rd`=1 with `mem_addr`=current index → LOAD.
  - LOAD: registers `mem_rdata` into `cost_init` and the current coordinates into `row`/`col` → ISSUE.
  - ISSUE: if `hold`=0, `en`=1 and the index advances. If `hold`=1, stay in ISSUE with `en`=0 and outputs stable.
  - GAP: counter runs ISSUE_INTERVAL-3 cycles, then → READ. GAP is skipped (ISSUE→READ) when ISSUE_INTERVAL=3.
- Index advance:
  - `col`+1; at IMG_COLS-1, `col`→0 and `row`+1.
  - The linear index increments alongside. No multiplier is used.
- Last pixel (IMG_ROWS-1, IMG_COLS-1) issued:
  - `frame_done`=1 and `frame_cnt`+1 in the same cycle as `en`.
  - Index, row and col reset to 0.
  - `loop`=1 → GAP, with identical spacing to frame pixel 0. `loop`=0 → IDLE.
- `hold`:
  - Freezes the GAP counter and blocks `en` in ISSUE.
  - Ignored in READ and LOAD, so fetched data is never lost.
- `start` is ignored while `busy`=1. `loop` is sampled at the last pixel.
- `row`/`col`/`cost_init` change only at the LOAD edge. They are meaningful only when `en`=1.

## Timing
- Reset (async assert, `rst`=0): all outputs 0, `cost_init`=0, state IDLE, counters and index 0.
- Reset release: takes effect synchronously on the next clock edge.
- Reset asserted mid-frame: aborts immediately. No `frame_done` is produced, and the next frame starts at pixel 0.
- Start latency: `start` high in cycle c (idle) → `mem_rd` in c+1, `busy` from c+1, `en` for pixel 0 in c+3.
- Pacing: consecutive `en` pulses are exactly ISSUE_INTERVAL cycles apart, plus one cycle for each cycle `hold`=1 in GAP or ISSUE.
- Loop: frame k pixel 0 `en` comes ISSUE_INTERVAL cycles after frame k-1 last `en` (unheld). There is no extra bubble.
- End of frame (`loop`=0): `busy` falls in the cycle after the last `en`. A `start` in that cycle is accepted.
- `hold` and the last pixel together: `frame_done` is deferred with `en`. It is never asserted without `en`.
- `frame_cnt` 31→0 on the 32nd frame completion.

## Test plan
- Reset values: assert `rst`=0 mid-run → all outputs 0 asynchronously. After release, `busy`=0 and no `en` without `start`.
- Single frame:
  - Setup: IMG_ROWS=2, IMG_COLS=3, ISSUE_INTERVAL=13, memory word i = i, `start` in cycle 10.
  - `en` at cycles 13, 26, …, 78.
  - `cost_init`=0..5 with (row,col)=(0,0),(0,1),(0,2),(1,0),(1,1),(1,2).
  - `mem_addr`=0..5.
  - `frame_done` at cycle 78, `frame_cnt`=1, `busy`=0 from cycle 79.
- Loop:
  - Setup: `loop`=1, same setup as single frame.
  - Frame 2 pixel 0 `en` at cycle 91 with `cost_init`=0.
  - After 32 frames `frame_cnt`=0. `start` pulses while busy have no effect.
- Hold:
  - `hold`=1 for 4 cycles during GAP → next `en` delayed by exactly 4.
  - `hold`=1 for 3 cycles in ISSUE → `en` low, `cost_init`/`row`/`col` stable, then `en`=1 the cycle `hold` falls.
  - `hold` asserted on the last pixel → `frame_done` moves with `en`.
- ISSUE_INTERVAL=3: `en` every 3rd cycle. Every `mem_rd` is followed two cycles later by `en` with the matching data.
- Reset mid-frame: `rst` low during pixel 3 → no `frame_done`, `frame_cnt`=0. A new `start` yields pixel 0 (`cost_init`=0) 3 cycles later.

Source files
------------

// File: rtl/aggr_cost_feeder.sv
// aggr_cost_feeder: raster-order stream source for aggregate_cost.
// Fetches one cost vector per pixel from a synchronous memory and presents it
// with its coordinates on a one-cycle strobe at a fixed pacing interval,
// with back-pressure, single-frame or continuous looping operation.
module aggr_cost_feeder #(
  parameter int DATA_WIDTH     = 864,
  parameter int DIM_WIDTH      = 10,
  parameter int IMG_ROWS       = 200,
  parameter int IMG_COLS       = 400,
  parameter int ADDR_WIDTH     = 17,
  parameter int ISSUE_INTERVAL = 13
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  loop,
  input  logic                  hold,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] cost_init,
  output logic [DIM_WIDTH-1:0]  row,
  output logic [DIM_WIDTH-1:0]  col,
  output logic                  en,
  output logic                  busy,
  output logic                  frame_done,
  output logic [4:0]            frame_cnt
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_ISSUE = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  // GAP lasts ISSUE_INTERVAL-3 cycles; the counter runs 0 .. GAP_LAST.
  localparam int GW = $clog2(ISSUE_INTERVAL);
  localparam logic [GW-1:0] GAP_LAST = GW'((ISSUE_INTERVAL > 3) ? (ISSUE_INTERVAL - 4) : 0);
  localparam logic [2:0] S_AFTER_ISSUE = (ISSUE_INTERVAL == 3) ? S_READ : S_GAP;

  localparam logic [DIM_WIDTH-1:0] ROW_LAST = DIM_WIDTH'(IMG_ROWS - 1);
  localparam logic [DIM_WIDTH-1:0] COL_LAST = DIM_WIDTH'(IMG_COLS - 1);

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [DIM_WIDTH-1:0]  prow_q, prow_d;
  logic [DIM_WIDTH-1:0]  pcol_q, pcol_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic [DATA_WIDTH-1:0] cost_q, cost_d;
  logic [DIM_WIDTH-1:0]  row_q, row_d;
  logic [DIM_WIDTH-1:0]  col_q, col_d;
  logic [4:0]            fcnt_q, fcnt_d;

  logic last_px;
  logic fire;

  assign last_px = (prow_q == ROW_LAST) && (pcol_q == COL_LAST);
  assign fire    = (state_q == S_ISSUE) && !hold;

  // Next-state logic: sequencing, pixel pointer advance and output capture.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    prow_d  = prow_q;
    pcol_d  = pcol_q;
    gap_d   = gap_q;
    cost_d  = cost_q;
    row_d   = row_q;
    col_d   = col_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_READ;
      end
      S_READ: begin
        state_d = S_LOAD;
      end
      S_LOAD: begin
        cost_d  = mem_rdata;
        row_d   = prow_q;
        col_d   = pcol_q;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (!hold) begin
          gap_d = '0;
          if (last_px) begin
            idx_d   = '0;
            prow_d  = '0;
            pcol_d  = '0;
            fcnt_d  = fcnt_q + 5'd1;
            state_d = loop ? S_AFTER_ISSUE : S_IDLE;
          end else begin
            idx_d = idx_q + ADDR_WIDTH'(1);
            if (pcol_q == COL_LAST) begin
              pcol_d = '0;
              prow_d = prow_q + DIM_WIDTH'(1);
            end else begin
              pcol_d = pcol_q + DIM_WIDTH'(1);
            end
            state_d = S_AFTER_ISSUE;
          end
        end
      end
      S_GAP: begin
        if (!hold) begin
          if (gap_q == GAP_LAST) state_d = S_READ;
          else                   gap_d   = gap_q + GW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; asynchronous active-low reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      prow_q  <= '0;
      pcol_q  <= '0;
      gap_q   <= '0;
      cost_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      prow_q  <= prow_d;
      pcol_q  <= pcol_d;
      gap_q   <= gap_d;
      cost_q  <= cost_d;
      row_q   <= row_d;
      col_q   <= col_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign mem_rd     = (state_q == S_READ);
  assign mem_addr   = idx_q;
  assign cost_init  = cost_q;
  assign row        = row_q;
  assign col        = col_q;
  assign en         = fire;
  assign busy       = (state_q != S_IDLE);
  assign frame_done = fire && last_px;
  assign frame_cnt  = fcnt_q;

endmodule

// File: tb/tb_aggr_cost_feeder.sv
// Directed self-checking bench for aggr_cost_feeder: a 2x3 frame at
// interval 13 (instance a) and at interval 3 (instance b).
module tb_aggr_cost_feeder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance a: interval 13
  logic        a_start = 1'b0, a_loop = 1'b0, a_hold = 1'b0;
  logic        a_mem_rd, a_en, a_busy, a_fd;
  logic [16:0] a_mem_addr;
  logic [15:0] a_rdata = '0, a_cost;
  logic [9:0]  a_row, a_col;
  logic [4:0]  a_fcnt;

  aggr_cost_feeder #(
    .DATA_WIDTH(16), .DIM_WIDTH(10), .IMG_ROWS(2), .IMG_COLS(3),
    .ADDR_WIDTH(17), .ISSUE_INTERVAL(13)
  ) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .loop(a_loop), .hold(a_hold),
    .mem_rd(a_mem_rd), .mem_addr(a_mem_addr), .mem_rdata(a_rdata),
    .cost_init(a_cost), .row(a_row), .col(a_col), .en(a_en),
    .busy(a_busy), .frame_done(a_fd), .frame_cnt(a_fcnt)
  );

  // Instance b: interval 3
  logic        b_start = 1'b0;
  logic        b_mem_rd, b_en, b_busy, b_fd;
  logic [16:0] b_mem_addr;
  logic [15:0] b_rdata = '0, b_cost;
  logic [9:0]  b_row, b_col;
  logic [4:0]  b_fcnt;

  aggr_cost_feeder #(
    .DATA_WIDTH(16), .DIM_WIDTH(10), .IMG_ROWS(2), .IMG_COLS(3),
    .ADDR_WIDTH(17), .ISSUE_INTERVAL(3)
  ) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .loop(1'b0), .hold(1'b0),
    .mem_rd(b_mem_rd), .mem_addr(b_mem_addr), .mem_rdata(b_rdata),
    .cost_init(b_cost), .row(b_row), .col(b_col), .en(b_en),
    .busy(b_busy), .frame_done(b_fd), .frame_cnt(b_fcnt)
  );

  // Synchronous memories: word i holds i, one-cycle read latency.
  always @(posedge clk) begin
    if (a_mem_rd) a_rdata <= 16'(a_mem_addr);
    if (b_mem_rd) b_rdata <= 16'(b_mem_addr);
  end

  // Event recorders, sampled mid-cycle.
  int          a_en_cyc[$], a_en_row[$], a_en_col[$], a_en_fd[$], a_rd_addr[$];
  logic [15:0] a_en_dat[$];
  int          b_en_cyc[$], b_en_fd[$], b_rd_cyc[$];
  logic [15:0] b_en_dat[$];
  int          a_fd_n = 0, a_orphan = 0, a_last_busy = 0, b_orphan = 0;

  always @(negedge clk) begin
    if (a_en) begin
      a_en_cyc.push_back(cyc);
      a_en_dat.push_back(a_cost);
      a_en_row.push_back(int'(a_row));
      a_en_col.push_back(int'(a_col));
      a_en_fd.push_back(int'(a_fd));
    end
    if (a_fd) begin
      a_fd_n = a_fd_n + 1;
      if (!a_en) a_orphan = a_orphan + 1;
    end
    if (a_mem_rd) a_rd_addr.push_back(int'(a_mem_addr));
    if (a_busy) a_last_busy = cyc;
    if (b_en) begin
      b_en_cyc.push_back(cyc);
      b_en_dat.push_back(b_cost);
      b_en_fd.push_back(int'(b_fd));
    end
    if (b_fd && !b_en) b_orphan = b_orphan + 1;
    if (b_mem_rd) b_rd_cyc.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input int t0, input int off);
    while (cyc < t0 + off) tick();
  endtask

  task automatic chk_a_zero(input string tag);
    chk({tag, "_busy"}, 64'(a_busy), 0);
    chk({tag, "_en"}, 64'(a_en), 0);
    chk({tag, "_mem_rd"}, 64'(a_mem_rd), 0);
    chk({tag, "_addr"}, 64'(a_mem_addr), 0);
    chk({tag, "_cost"}, 64'(a_cost), 0);
    chk({tag, "_row"}, 64'(a_row), 0);
    chk({tag, "_col"}, 64'(a_col), 0);
    chk({tag, "_fd"}, 64'(a_fd), 0);
    chk({tag, "_fcnt"}, 64'(a_fcnt), 0);
  endtask

  task automatic wait_a_idle(input string tag);
    for (int i = 0; i < 300 && a_busy; i++) tick();
    chk({tag, "_idle"}, 64'(a_busy), 0);
  endtask

  task automatic pulse_a_start(output int t0);
    a_start = 1'b1;
    t0 = cyc;
    tick();
    a_start = 1'b0;
  endtask

  initial begin
    int t0, base, fb, errs, en_n;

    // ---- Reset values (asynchronous assertion) ----
    #2 rst = 1'b0;
    #1 chk_a_zero("rst0");
    chk("rst0_b_busy", 64'(b_busy), 0);
    repeat (3) tick();
    rst = 1'b1;
    en_n = a_en_cyc.size();
    repeat (5) tick();
    chk("post_rst_busy", 64'(a_busy), 0);
    chk("post_rst_no_en", 64'(a_en_cyc.size()), 64'(en_n));

    // ---- Single frame ----
    base = a_en_cyc.size();
    fb = a_rd_addr.size();
    pulse_a_start(t0);
    chk("start_mem_rd", 64'(a_mem_rd), 1);
    chk("start_busy", 64'(a_busy), 1);
    go(t0, 72);
    chk("sf_count", 64'(a_en_cyc.size() - base), 6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("sf_en_cyc%0d", i), 64'(a_en_cyc[base+i] - t0), 64'(3 + 13*i));
      chk($sformatf("sf_dat%0d", i), 64'(a_en_dat[base+i]), 64'(i));
      chk($sformatf("sf_row%0d", i), 64'(a_en_row[base+i]), 64'(i / 3));
      chk($sformatf("sf_col%0d", i), 64'(a_en_col[base+i]), 64'(i % 3));
      chk($sformatf("sf_fd%0d", i), 64'(a_en_fd[base+i]), 64'(i == 5));
      chk($sformatf("sf_addr%0d", i), 64'(a_rd_addr[fb+i]), 64'(i));
    end
    chk("sf_last_busy", 64'(a_last_busy - t0), 68);
    chk("sf_fcnt", 64'(a_fcnt), 1);
    chk("sf_orphan", 64'(a_orphan), 0);

    // ---- Loop: 32 frames with start pulses while busy ----
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("loop_pre_fcnt", 64'(a_fcnt), 0);
    base = a_en_cyc.size();
    fb = a_fd_n;
    a_loop = 1'b1;
    pulse_a_start(t0);
    for (int i = 0; i < 3000 && (a_fd_n - fb) < 31; i++) begin
      a_start = (i % 97 == 50);
      tick();
    end
    a_start = 1'b0;
    chk("loop_fd31", 64'(a_fd_n - fb), 31);
    chk("loop_fcnt31", 64'(a_fcnt), 31);
    a_loop = 1'b0;
    for (int i = 0; i < 200 && (a_fd_n - fb) < 32; i++) tick();
    chk("loop_fd32", 64'(a_fd_n - fb), 32);
    chk("loop_fcnt_wrap", 64'(a_fcnt), 0);
    wait_a_idle("loop");
    chk("loop_en_total", 64'(a_en_cyc.size() - base), 192);
    chk("loop_f2_p0_cyc", 64'(a_en_cyc[base+6] - t0), 81);
    chk("loop_f2_p0_dat", 64'(a_en_dat[base+6]), 0);
    errs = 0;
    for (int i = 1; i < 192; i++)
      if (a_en_cyc[base+i] - a_en_cyc[base+i-1] != 13) errs++;
    chk("loop_spacing_errs", 64'(errs), 0);
    errs = 0;
    for (int i = 0; i < 192; i++)
      if (a_en_dat[base+i] != 16'(i % 6) || a_en_row[base+i] != (i % 6) / 3 ||
          a_en_col[base+i] != i % 3 || a_en_fd[base+i] != int'(i % 6 == 5)) errs++;
    chk("loop_data_errs", 64'(errs), 0);

    // ---- Hold in GAP, in ISSUE, and on the last pixel ----
    tick();
    base = a_en_cyc.size();
    fb = a_fd_n;
    pulse_a_start(t0);
    go(t0, 5);  a_hold = 1'b1;
    go(t0, 9);  a_hold = 1'b0;
    go(t0, 33); a_hold = 1'b1;
    #1 chk("hold_issue_en_low0", 64'(a_en), 0);
    go(t0, 35);
    chk("hold_issue_en_low2", 64'(a_en), 0);
    chk("hold_issue_cost", 64'(a_cost), 2);
    chk("hold_issue_row", 64'(a_row), 0);
    chk("hold_issue_col", 64'(a_col), 2);
    go(t0, 36); a_hold = 1'b0;
    #1 chk("hold_release_en", 64'(a_en), 1);
    go(t0, 75); a_hold = 1'b1;
    go(t0, 77); a_hold = 1'b0;
    wait_a_idle("hold");
    chk("hold_count", 64'(a_en_cyc.size() - base), 6);
    chk("hold_gap_en1", 64'(a_en_cyc[base+1] - t0), 20);
    chk("hold_issue_en2", 64'(a_en_cyc[base+2] - t0), 36);
    chk("hold_en3", 64'(a_en_cyc[base+3] - t0), 49);
    chk("hold_last_en5", 64'(a_en_cyc[base+5] - t0), 77);
    chk("hold_last_fd", 64'(a_en_fd[base+5]), 1);
    chk("hold_fd_n", 64'(a_fd_n - fb), 1);
    chk("hold_orphan", 64'(a_orphan), 0);
    chk("hold_fcnt", 64'(a_fcnt), 1);

    // ---- Interval 3 ----
    base = b_en_cyc.size();
    fb = b_rd_cyc.size();
    b_start = 1'b1;
    t0 = cyc;
    tick();
    b_start = 1'b0;
    go(t0, 25);
    chk("iv3_count", 64'(b_en_cyc.size() - base), 6);
    errs = 0;
    for (int i = 0; i < 6; i++) begin
      if (b_en_cyc[base+i] - t0 != 3 + 3*i) errs++;
      if (b_en_dat[base+i] != 16'(i)) errs++;
      if (b_rd_cyc[fb+i] + 2 != b_en_cyc[base+i]) errs++;
      if (b_en_fd[base+i] != int'(i == 5)) errs++;
    end
    chk("iv3_errs", 64'(errs), 0);
    chk("iv3_orphan", 64'(b_orphan), 0);
    chk("iv3_busy", 64'(b_busy), 0);
    chk("iv3_fcnt", 64'(b_fcnt), 1);

    // ---- Reset mid-frame during pixel 3 ----
    tick();
    fb = a_fd_n;
    pulse_a_start(t0);
    go(t0, 42);
    chk("midrst_en_before", 64'(a_en), 1);
    rst = 1'b0;
    #1 chk_a_zero("midrst");
    tick();
    tick();
    rst = 1'b1;
    base = a_en_cyc.size();
    repeat (4) tick();
    chk("midrst_no_fd", 64'(a_fd_n - fb), 0);
    chk("midrst_idle_no_en", 64'(a_en_cyc.size() - base), 0);
    chk("midrst_fcnt", 64'(a_fcnt), 0);
    pulse_a_start(t0);
    go(t0, 3);
    chk("midrst_p0_en", 64'(a_en), 1);
    chk("midrst_p0_cost", 64'(a_cost), 0);
    chk("midrst_p0_row", 64'(a_row), 0);
    chk("midrst_p0_col", 64'(a_col), 0);
    wait_a_idle("midrst");
    chk("midrst_fcnt_after", 64'(a_fcnt), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
